// File: rtl/swipt_freq_sched_pkg.sv
// Shared types and constants for the SWIPT frequency scheduler.
// Holds the FSM encoding, idle drive values and the edge-count helper.
package swipt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DWELL   = 3'd1,
      APPLY   = 3'd2,
      TRACK   = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   localparam logic [31:0] F_DEFAULT = 32'h0000_9C40;
   localparam logic [11:0] L_DEFAULT = 12'h0FA;
   localparam int          CNT_W     = 16;

   // Saturating increment so a noisy comparator never wraps the count back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      logic [CNT_W-1:0] r;
      r = v;
      if (inc && (v != {CNT_W{1'b1}})) begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/swipt_freq_sched_edge_window_counter.sv
// Counts rising edges of the comparator inside fixed-length dwell windows.
// win_cnt already includes an edge landing in the window's final cycle.
module edge_window_counter
   import swipt_pkg::*;
#(
   parameter int DWELL_CYC = 1000
)
(
   input  logic             clk,
   input  logic             nrst,
   input  logic             clr,
   input  logic             adc_comp,
   output logic             win_end,
   output logic [CNT_W-1:0] win_cnt
);

   localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

   logic             adc_q_r;
   logic [DW_W-1:0]  dwell_r;
   logic [CNT_W-1:0] cnt_r;
   logic             edge_s;

   assign edge_s  = adc_comp & ~adc_q_r;
   assign win_end = (dwell_r == DW_W'(DWELL_CYC - 1));
   assign win_cnt = sat_inc(cnt_r, edge_s);

   // Comparator history, dwell position and running edge count; windows restart on their own.
   always_ff @(posedge clk) begin
      if (nrst) begin
         adc_q_r <= 1'b0;
         dwell_r <= '0;
         cnt_r   <= '0;
      end else begin
         adc_q_r <= adc_comp;
         if (clr || win_end) begin
            dwell_r <= '0;
            cnt_r   <= '0;
         end else begin
            dwell_r <= dwell_r + DW_W'(1);
            cnt_r   <= win_cnt;
         end
      end
   end

endmodule

// File: rtl/swipt_freq_sched.sv
// Sweeps the SwiptOut drive frequency, picks the point with the most comparator
// edges, then hands tracking to the PLL and re-sweeps when lock or link is lost.
module swipt_freq_sched
   import swipt_pkg::*;
#(
   parameter logic [31:0] F_MIN      = 32'h0000_88B8,
   parameter logic [31:0] F_MAX      = 32'h0000_AFC8,
   parameter logic [31:0] F_STEP     = 32'h0000_01F4,
   parameter int          DWELL_CYC  = 1000,
   parameter int          LOST_LIMIT = 256,
   parameter int          HOLD_CYC   = 1000
)
(
   input  logic             clk,
   input  logic             nrst,
   input  logic             swipt_alive,
   input  logic             adc_comp,
   input  logic             pll_lock,
   output logic [31:0]      freq,
   output logic [11:0]      l,
   output logic             load_freq,
   output logic             pll_en,
   output logic             sweep_done,
   output logic [CNT_W-1:0] best_cnt,
   output logic [2:0]       state
);

   localparam int LOST_W = (LOST_LIMIT > 1) ? $clog2(LOST_LIMIT) : 1;
   localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   state_t           state_r;
   logic [31:0]      freq_r;
   logic [11:0]      l_r;
   logic             load_r;
   logic             pll_en_r;
   logic             done_r;
   logic [CNT_W-1:0] best_cnt_r;
   logic [31:0]      best_freq_r;
   logic [LOST_W-1:0] lost_r;
   logic [HOLD_W-1:0] hold_r;

   logic             clr_s;
   logic             win_end_s;
   logic [CNT_W-1:0] win_cnt_s;
   logic [32:0]      next_freq_s;
   logic             past_max_s;

   // Windows only run while dwelling, so every other state keeps them cleared.
   assign clr_s       = (state_r != DWELL);
   // Widened to 33 bits so a step near the top of the range cannot wrap.
   assign next_freq_s = {1'b0, freq_r} + {1'b0, F_STEP};
   assign past_max_s  = (next_freq_s > {1'b0, F_MAX});

   edge_window_counter #(
      .DWELL_CYC (DWELL_CYC)
   ) u_win (
      .clk      (clk),
      .nrst     (nrst),
      .clr      (clr_s),
      .adc_comp (adc_comp),
      .win_end  (win_end_s),
      .win_cnt  (win_cnt_s)
   );

   // Scheduler FSM with registered frequency, handshake pulses and sweep bookkeeping.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_r     <= IDLE;
         freq_r      <= F_DEFAULT;
         l_r         <= L_DEFAULT;
         load_r      <= 1'b0;
         pll_en_r    <= 1'b0;
         done_r      <= 1'b0;
         best_cnt_r  <= '0;
         best_freq_r <= F_MIN;
         lost_r      <= '0;
         hold_r      <= '0;
      end else begin
         l_r    <= L_DEFAULT;
         load_r <= 1'b0;
         done_r <= 1'b0;
         if ((state_r != IDLE) && !swipt_alive) begin
            state_r  <= IDLE;
            freq_r   <= F_DEFAULT;
            load_r   <= (freq_r != F_DEFAULT);
            pll_en_r <= 1'b0;
            lost_r   <= '0;
            hold_r   <= '0;
         end else begin
            case (state_r)
               IDLE: begin
                  pll_en_r <= 1'b0;
                  if (swipt_alive) begin
                     state_r     <= DWELL;
                     freq_r      <= F_MIN;
                     load_r      <= 1'b1;
                     best_cnt_r  <= '0;
                     best_freq_r <= F_MIN;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               DWELL: begin
                  if (win_end_s) begin
                     // Strictly greater: a tie keeps the earlier, lower frequency.
                     if (win_cnt_s > best_cnt_r) begin
                        best_cnt_r  <= win_cnt_s;
                        best_freq_r <= freq_r;
                     end else begin
                        best_cnt_r  <= best_cnt_r;
                     end
                     if (past_max_s) begin
                        state_r <= APPLY;
                     end else begin
                        freq_r  <= next_freq_s[31:0];
                        load_r  <= 1'b1;
                     end
                  end else begin
                     state_r <= DWELL;
                  end
               end
               APPLY: begin
                  if (best_cnt_r == '0) begin
                     state_r <= HOLDOFF;
                     freq_r  <= F_DEFAULT;
                     load_r  <= 1'b1;
                     hold_r  <= '0;
                  end else begin
                     state_r  <= TRACK;
                     freq_r   <= best_freq_r;
                     load_r   <= (best_freq_r != freq_r);
                     done_r   <= 1'b1;
                     pll_en_r <= 1'b1;
                     lost_r   <= '0;
                  end
               end
               TRACK: begin
                  if (pll_lock) begin
                     lost_r <= '0;
                  end else if (lost_r == LOST_W'(LOST_LIMIT - 1)) begin
                     state_r     <= DWELL;
                     pll_en_r    <= 1'b0;
                     freq_r      <= F_MIN;
                     load_r      <= 1'b1;
                     best_cnt_r  <= '0;
                     best_freq_r <= F_MIN;
                     lost_r      <= '0;
                  end else begin
                     lost_r <= lost_r + LOST_W'(1);
                  end
               end
               HOLDOFF: begin
                  if (hold_r == HOLD_W'(HOLD_CYC - 1)) begin
                     state_r <= IDLE;
                     hold_r  <= '0;
                  end else begin
                     hold_r  <= hold_r + HOLD_W'(1);
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  freq_r   <= F_DEFAULT;
                  pll_en_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign freq       = freq_r;
   assign l          = l_r;
   assign load_freq  = load_r;
   assign pll_en     = pll_en_r;
   assign sweep_done = done_r;
   assign best_cnt   = best_cnt_r;
   assign state      = state_r;

endmodule

// File: tb/tb_swipt_freq_sched.sv
// Self-checking bench for swipt_freq_sched: table-driven sweeps, hand-written
// corner sequences and randomized sweeps against a transaction-level model.
module tb_swipt_freq_sched;

   localparam int T_FMIN  = 39000;
   localparam int T_FMAX  = 41000;
   localparam int T_STEP  = 500;
   localparam int T_DWELL = 16;
   localparam int T_HOLD  = 16;
   localparam int T_FDEF  = 40000;
   localparam int NPTS    = (T_FMAX - T_FMIN) / T_STEP + 1;

   localparam int S_IDLE = 0, S_DWELL = 1, S_APPLY = 2, S_TRACK = 3, S_HOLD = 4;
   localparam int R_ABORT = 0, R_TRACK = 1, R_HOLD = 2;

   logic        clk;
   logic        nrst;
   logic        swipt_alive;
   logic        adc_comp;
   logic        pll_lock;
   logic [31:0] freq;
   logic [11:0] l;
   logic        load_freq;
   logic        pll_en;
   logic        sweep_done;
   logic [15:0] best_cnt;
   logic [2:0]  state;

   int checks;
   int failures;

   typedef struct {
      logic [19:0] pat;
      int          ef;
      int          eb;
      int          ap;
      int          ac;
   } vec_t;

   vec_t tbl [7];

   swipt_freq_sched #(
      .F_MIN      (32'd39000),
      .F_MAX      (32'd41000),
      .F_STEP     (32'd500),
      .DWELL_CYC  (16),
      .LOST_LIMIT (8),
      .HOLD_CYC   (16)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .swipt_alive (swipt_alive),
      .adc_comp    (adc_comp),
      .pll_lock    (pll_lock),
      .freq        (freq),
      .l           (l),
      .load_freq   (load_freq),
      .pll_en      (pll_en),
      .sweep_done  (sweep_done),
      .best_cnt    (best_cnt),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] mkpat(input int e0, input int e1, input int e2, input int e3, input int e4);
      return {4'(e4), 4'(e3), 4'(e2), 4'(e1), 4'(e0)};
   endfunction

   // Starts at the negedge where the first sweep point is visible; ends one cycle after APPLY.
   task automatic run_sweep(input bit rnd, input logic [19:0] pat, input int t_f, input int t_b,
                            input int ap, input int ac, output int res, output int ef);
      int prev, cnt, best, bestf, f, dens, eb;
      logic [3:0] k;
      bit b;
      prev  = adc_comp ? 1 : 0;
      best  = 0;
      bestf = T_FMIN;
      chk("sweep_start_state", state, S_DWELL);
      chk("sweep_start_best", best_cnt, 0);
      for (int p = 0; p < NPTS; p++) begin
         f    = T_FMIN + p * T_STEP;
         cnt  = 0;
         dens = $urandom_range(0, 4);
         k    = pat[p*4 +: 4];
         for (int c = 0; c < T_DWELL; c++) begin
            if (p == ap && c == ac) begin
               swipt_alive = 1'b0;
               @(negedge clk);
               chk("abort_state", state, S_IDLE);
               chk("abort_freq", freq, T_FDEF);
               chk("abort_load", load_freq, 1);
               chk("abort_pll_en", pll_en, 0);
               chk("abort_best", best_cnt, rnd ? best : t_b);
               res = R_ABORT;
               ef  = 0;
               return;
            end
            chk("sweep_freq", freq, f);
            chk("sweep_load", load_freq, (c == 0) ? 1 : 0);
            chk("sweep_done_low", sweep_done, 0);
            if (rnd) b = ($urandom_range(0, 3) < dens);
            else     b = (c < 2 * k) && (c % 2 == 0);
            if (b && prev == 0) cnt++;
            prev     = b ? 1 : 0;
            adc_comp = b;
            @(negedge clk);
         end
         if (cnt > best) begin
            best  = cnt;
            bestf = f;
         end
      end
      ef = rnd ? bestf : t_f;
      eb = rnd ? best : t_b;
      chk("apply_state", state, S_APPLY);
      chk("apply_freq_held", freq, T_FMAX);
      chk("apply_load", load_freq, 0);
      adc_comp = 1'b0;
      @(negedge clk);
      if (eb == 0) begin
         res = R_HOLD;
         chk("hold_state", state, S_HOLD);
         chk("hold_freq", freq, T_FDEF);
         chk("hold_load", load_freq, 1);
         chk("hold_done", sweep_done, 0);
         chk("hold_pll_en", pll_en, 0);
      end else begin
         res = R_TRACK;
         chk("track_state", state, S_TRACK);
         chk("track_freq", freq, ef);
         chk("track_load", load_freq, (ef != T_FMAX) ? 1 : 0);
         chk("track_done", sweep_done, 1);
         chk("track_pll_en", pll_en, 1);
         chk("track_best", best_cnt, eb);
      end
   endtask

   task automatic start_sweep();
      swipt_alive = 1'b1;
      @(negedge clk);
   endtask

   task automatic finish_track(input int ef);
      swipt_alive = 1'b0;
      @(negedge clk);
      chk("drop_state", state, S_IDLE);
      chk("drop_freq", freq, T_FDEF);
      chk("drop_load", load_freq, (ef != T_FDEF) ? 1 : 0);
      chk("drop_pll_en", pll_en, 0);
      chk("drop_done", sweep_done, 0);
   endtask

   task automatic finish_holdoff();
      for (int i = 1; i < T_HOLD; i++) begin
         @(negedge clk);
         chk("holdoff_wait", state, S_HOLD);
      end
      @(negedge clk);
      chk("holdoff_idle", state, S_IDLE);
      chk("holdoff_idle_freq", freq, T_FDEF);
      @(negedge clk);
      chk("holdoff_restart", state, S_DWELL);
      chk("holdoff_restart_freq", freq, T_FMIN);
      chk("holdoff_restart_load", load_freq, 1);
      swipt_alive = 1'b0;
      @(negedge clk);
      chk("holdoff_drop_state", state, S_IDLE);
      chk("holdoff_drop_load", load_freq, 1);
   endtask

   task automatic finish_any(input int res, input int ef);
      if (res == R_TRACK)     finish_track(ef);
      else if (res == R_HOLD) finish_holdoff();
      else                    swipt_alive = 1'b0;
   endtask

   initial begin
      int res, ef;
      bit lk;
      checks      = 0;
      failures    = 0;
      nrst        = 1'b1;
      swipt_alive = 1'b0;
      adc_comp    = 1'b0;
      pll_lock    = 1'b1;

      tbl[0] = '{mkpat(0, 0, 8, 0, 0), 40000, 8, NPTS, 0};
      tbl[1] = '{mkpat(0, 4, 0, 4, 0), 39500, 4, NPTS, 0};
      tbl[2] = '{mkpat(0, 0, 0, 0, 0), 40000, 0, NPTS, 0};
      tbl[3] = '{mkpat(1, 2, 3, 2, 1), 40000, 3, NPTS, 0};
      tbl[4] = '{mkpat(5, 0, 0, 0, 5), 39000, 5, NPTS, 0};
      tbl[5] = '{mkpat(0, 0, 0, 0, 7), 41000, 7, NPTS, 0};
      tbl[6] = '{mkpat(0, 0, 8, 2, 0), 0,     8, 3,    5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_freq", freq, T_FDEF);
      chk("rst_l", l, 32'h0FA);
      chk("rst_pll_en", pll_en, 0);
      chk("rst_state", state, S_IDLE);
      chk("rst_load", load_freq, 0);
      chk("rst_best", best_cnt, 0);
      chk("rst_done", sweep_done, 0);
      nrst = 1'b0;
      @(negedge clk);
      chk("idle_state", state, S_IDLE);
      chk("idle_load", load_freq, 0);

      for (int r = 0; r < 7; r++) begin
         start_sweep();
         run_sweep(1'b0, tbl[r].pat, tbl[r].ef, tbl[r].eb, tbl[r].ap, tbl[r].ac, res, ef);
         finish_any(res, ef);
         @(negedge clk);
      end

      // Lock loss: the single locked cycle must restart the unlocked run.
      start_sweep();
      run_sweep(1'b0, mkpat(0, 0, 8, 0, 0), 40000, 8, NPTS, 0, res, ef);
      for (int i = 0; i < 16; i++) begin
         lk       = (i == 7);
         pll_lock = lk;
         @(negedge clk);
         if (i < 15) begin
            chk("lost_track_state", state, S_TRACK);
            chk("lost_track_pll_en", pll_en, 1);
         end else begin
            chk("lost_resweep_state", state, S_DWELL);
            chk("lost_resweep_pll_en", pll_en, 0);
            chk("lost_resweep_freq", freq, T_FMIN);
            chk("lost_resweep_load", load_freq, 1);
            chk("lost_resweep_best", best_cnt, 0);
         end
      end
      pll_lock = 1'b1;
      run_sweep(1'b1, 20'h0, 0, 0, NPTS, 0, res, ef);
      finish_any(res, ef);
      @(negedge clk);

      for (int n = 0; n < 6; n++) begin
         start_sweep();
         run_sweep(1'b1, 20'h0, 0, 0, NPTS, 0, res, ef);
         finish_any(res, ef);
         @(negedge clk);
      end

      // Reset in the middle of a sweep returns to idle values without a load pulse.
      start_sweep();
      repeat (T_DWELL + 4) @(negedge clk);
      chk("midrst_pre_freq", freq, T_FMIN + T_STEP);
      nrst        = 1'b1;
      swipt_alive = 1'b0;
      @(negedge clk);
      chk("midrst_freq", freq, T_FDEF);
      chk("midrst_load", load_freq, 0);
      chk("midrst_state", state, S_IDLE);
      chk("midrst_pll_en", pll_en, 0);
      chk("midrst_best", best_cnt, 0);
      nrst = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
